branch_fu: RTL

Branch functional unit for the out-of-order core: accepts issued conditional branches, JAL and JALR from the branch reservation station, resolves direction with a `cmp` instance, and computes the actual next PC, link value and mispredict flag. It is a two-stage pipeline (E1 resolve, E2 result hold) with valid/ready backpressure on both sides and broadcasts results on its CDB port toward the ROB and the fetch redirect logic.

---
 rtl/branch_fu.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/branch_fu.sv
// Branch functional unit: two-stage (E1 resolve, E2 hold) pipeline for conditional
// branches, JAL and JALR, broadcasting link value, next PC and mispredict on the CDB.

module cmp (
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        en
);
  always_comb begin
    en = 1'b0;
    case (op)
      3'b000:  en = (a == b);
      3'b001:  en = (a != b);
      3'b100:  en = ($signed(a) < $signed(b));
      3'b101:  en = ($signed(a) >= $signed(b));
      3'b110:  en = (a < b);
      3'b111:  en = (a >= b);
      default: en = 1'b0;  // 010/011 are not branch compares
    endcase
  end
endmodule

module branch_fu #(
  parameter int ROB_IDX_W  = 5,
  parameter int PHYS_REG_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  iss_valid,
  output logic                  iss_ready,
  input  logic [1:0]            iss_kind,
  input  logic [2:0]            iss_cmpop,
  input  logic [31:0]           iss_pc,
  input  logic [31:0]           iss_rs1_v,
  input  logic [31:0]           iss_rs2_v,
  input  logic [31:0]           iss_imm,
  input  logic                  iss_pred_taken,
  input  logic [31:0]           iss_pred_target,
  input  logic [ROB_IDX_W-1:0]  iss_rob_idx,
  input  logic [PHYS_REG_W-1:0] iss_pd,
  output logic                  cdb_valid,
  input  logic                  cdb_ready,
  output logic [ROB_IDX_W-1:0]  cdb_rob_idx,
  output logic [PHYS_REG_W-1:0] cdb_pd,
  output logic                  cdb_rd_we,
  output logic [31:0]           cdb_rd_v,
  output logic                  cdb_mispredict,
  output logic [31:0]           cdb_redirect_pc
);
  typedef enum logic [1:0] {
    KIND_BR   = 2'b00,
    KIND_JAL  = 2'b01,
    KIND_JALR = 2'b10,
    KIND_RSVD = 2'b11
  } kind_t;

  logic                  e1_valid;
  logic [1:0]            e1_kind;
  logic [2:0]            e1_cmpop;
  logic [31:0]           e1_pc;
  logic [31:0]           e1_rs1_v;
  logic [31:0]           e1_rs2_v;
  logic [31:0]           e1_imm;
  logic                  e1_pred_taken;
  logic [31:0]           e1_pred_target;
  logic [ROB_IDX_W-1:0]  e1_rob_idx;
  logic [PHYS_REG_W-1:0] e1_pd;

  logic                  e2_valid;
  logic [ROB_IDX_W-1:0]  e2_rob_idx;
  logic [PHYS_REG_W-1:0] e2_pd;
  logic                  e2_rd_we;
  logic [31:0]           e2_rd_v;
  logic                  e2_mispredict;
  logic [31:0]           e2_redirect_pc;

  logic        e1_advance;
  logic        accept;
  logic        br_en;
  logic [31:0] seq_pc;
  logic [31:0] br_tgt;
  logic [31:0] jalr_tgt;
  logic        res_rd_we;
  logic [31:0] res_rd_v;
  logic        res_mispredict;
  logic [31:0] res_redirect_pc;

  assign e1_advance = !e2_valid || (cdb_valid && cdb_ready);
  assign iss_ready  = !flush && (!e1_valid || e1_advance);
  assign accept     = iss_valid && iss_ready;

  cmp u_cmp (
    .op (e1_cmpop),
    .a  (e1_rs1_v),
    .b  (e1_rs2_v),
    .en (br_en)
  );

  assign seq_pc   = e1_pc + 32'd4;
  assign br_tgt   = e1_pc + e1_imm;
  assign jalr_tgt = (e1_rs1_v + e1_imm) & ~32'h1;

  always_comb begin
    res_rd_we       = 1'b0;
    res_rd_v        = 32'h0;
    res_mispredict  = 1'b0;
    res_redirect_pc = seq_pc;
    case (kind_t'(e1_kind))
      KIND_BR: begin
        res_redirect_pc = br_en ? br_tgt : seq_pc;
        res_mispredict  = (br_en != e1_pred_taken) ||
                          (br_en && (e1_pred_target != br_tgt));
      end
      KIND_JAL: begin
        res_redirect_pc = br_tgt;
        res_mispredict  = !e1_pred_taken || (e1_pred_target != br_tgt);
        res_rd_we       = 1'b1;
        res_rd_v        = seq_pc;
      end
      KIND_JALR: begin
        res_redirect_pc = jalr_tgt;
        res_mispredict  = !e1_pred_taken || (e1_pred_target != jalr_tgt);
        res_rd_we       = 1'b1;
        res_rd_v        = seq_pc;
      end
      default: begin
        res_redirect_pc = seq_pc;
      end
    endcase
  end

  // E1: capture an accepted issue, otherwise drain when E2 can take the op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e1_valid       <= 1'b0;
      e1_kind        <= 2'b00;
      e1_cmpop       <= 3'b000;
      e1_pc          <= 32'h0;
      e1_rs1_v       <= 32'h0;
      e1_rs2_v       <= 32'h0;
      e1_imm         <= 32'h0;
      e1_pred_taken  <= 1'b0;
      e1_pred_target <= 32'h0;
      e1_rob_idx     <= '0;
      e1_pd          <= '0;
    end else if (flush) begin
      e1_valid <= 1'b0;
    end else if (accept) begin
      e1_valid       <= 1'b1;
      e1_kind        <= iss_kind;
      e1_cmpop       <= iss_cmpop;
      e1_pc          <= iss_pc;
      e1_rs1_v       <= iss_rs1_v;
      e1_rs2_v       <= iss_rs2_v;
      e1_imm         <= iss_imm;
      e1_pred_taken  <= iss_pred_taken;
      e1_pred_target <= iss_pred_target;
      e1_rob_idx     <= iss_rob_idx;
      e1_pd          <= iss_pd;
    end else if (e1_advance) begin
      e1_valid <= 1'b0;
    end
  end

  // E2: payload only updates when a real op moves in, so a stalled result is stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e2_valid       <= 1'b0;
      e2_rob_idx     <= '0;
      e2_pd          <= '0;
      e2_rd_we       <= 1'b0;
      e2_rd_v        <= 32'h0;
      e2_mispredict  <= 1'b0;
      e2_redirect_pc <= 32'h0;
    end else if (flush) begin
      e2_valid <= 1'b0;
    end else if (e1_advance) begin
      e2_valid <= e1_valid;
      if (e1_valid) begin
        e2_rob_idx     <= e1_rob_idx;
        e2_pd          <= e1_pd;
        e2_rd_we       <= res_rd_we;
        e2_rd_v        <= res_rd_v;
        e2_mispredict  <= res_mispredict;
        e2_redirect_pc <= res_redirect_pc;
      end
    end
  end

  assign cdb_valid       = e2_valid;
  assign cdb_rob_idx     = e2_rob_idx;
  assign cdb_pd          = e2_pd;
  assign cdb_rd_we       = e2_rd_we;
  assign cdb_rd_v        = e2_rd_v;
  assign cdb_mispredict  = e2_mispredict;
  assign cdb_redirect_pc = e2_redirect_pc;
endmodule
